// File: rtl/adder_pipe_nbit_pkg.sv
// Shared helpers for the pipelined segmented adder: stage-count arithmetic,
// per-segment width and the per-stage valid/carry record.
package adder_pipe_pkg;

   typedef struct packed {
      logic valid;
      logic carry;
   } stage_ctl_t;

   function automatic int unsigned cdiv(input int unsigned a, input int unsigned b);
      return (a + b - 1) / b;
   endfunction

   // The last segment is narrower when WIDTH is not a multiple of SEG.
   function automatic int unsigned seg_w(input int unsigned k, input int unsigned width,
                                         input int unsigned seg);
      int unsigned lo;
      lo = k * seg;
      return (width - lo < seg) ? width - lo : seg;
   endfunction

endpackage

// File: rtl/adder_pipe_nbit_if.sv
// Valid/ready streaming bundle for adder_pipe_nbit: operand side in_*, result side out_*.
interface adder_pipe_nbit_if #(
   parameter int unsigned WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;
   logic             out_ovf;

   modport master (
      output in_valid, in_a, in_b, in_cin, out_ready,
      input  in_ready, out_valid, out_sum, out_cout, out_ovf
   );

   modport slave (
      input  in_valid, in_a, in_b, in_cin, out_ready,
      output in_ready, out_valid, out_sum, out_cout, out_ovf
   );
endinterface

// File: rtl/adder_pipe_nbit_seg.sv
// adder_seg: combinational W-bit full-adder slice, one instance per pipeline stage.
module adder_seg #(
   parameter int unsigned W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] s,
   output logic         cout
);
   assign {cout, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
endmodule

// File: rtl/adder_pipe_nbit.sv
// adder_pipe_nbit: WIDTH-bit A+B+cin, one SEG-bit segment per stage, carry registered between stages.
// Optional ADDER_PIPE_OVF_EN adds a registered signed-overflow flag on out_ovf.
module adder_pipe_nbit
   import adder_pipe_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SEG   = 8
) (
   input logic              clk,
   input logic              rst_n,
   adder_pipe_nbit_if.slave bus
);
   localparam int unsigned STAGES = cdiv(WIDTH, SEG);

   logic adv;

   // Whole pipe moves together; bubbles shift like data.
   assign adv          = !bus.out_valid || bus.out_ready;
   assign bus.in_ready = adv;

   for (genvar k = 0; k < STAGES; k++) begin : g_st
      localparam int unsigned LO = k * SEG;
      localparam int unsigned SW = seg_w(k, WIDTH, SEG);
      localparam int unsigned HI = LO + SW;

      // a_rem/b_rem hold operand bits [WIDTH-1:LO]; the low SW bits feed this stage.
      logic [WIDTH-LO-1:0] a_rem, b_rem;
      logic                cin_s, v_s;
      logic [SW-1:0]       s_seg;
      logic                cout_s;
      logic [HI-1:0]       sum_d, sum_q;
      stage_ctl_t          ctl_q;

      if (k == 0) begin : g_src
         assign a_rem = bus.in_a;
         assign b_rem = bus.in_b;
         assign cin_s = bus.in_cin;
         assign v_s   = bus.in_valid;
         assign sum_d = s_seg;
      end else begin : g_src
         assign a_rem = g_st[k-1].g_skew.a_q;
         assign b_rem = g_st[k-1].g_skew.b_q;
         assign cin_s = g_st[k-1].ctl_q.carry;
         assign v_s   = g_st[k-1].ctl_q.valid;
         assign sum_d = {s_seg, g_st[k-1].sum_q};
      end

      adder_seg #(.W(SW)) u_seg (
         .a    (a_rem[SW-1:0]),
         .b    (b_rem[SW-1:0]),
         .cin  (cin_s),
         .s    (s_seg),
         .cout (cout_s)
      );

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            ctl_q <= '0;
            sum_q <= '0;
         end else if (adv) begin
            ctl_q <= '{valid: v_s, carry: cout_s};
            sum_q <= sum_d;
         end
      end

      if (HI < WIDTH) begin : g_skew
         logic [WIDTH-HI-1:0] a_q, b_q;

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               a_q <= '0;
               b_q <= '0;
            end else if (adv) begin
               a_q <= a_rem[WIDTH-LO-1:SW];
               b_q <= b_rem[WIDTH-LO-1:SW];
            end
         end
      end
   end

   assign bus.out_valid = g_st[STAGES-1].ctl_q.valid;
   assign bus.out_cout  = g_st[STAGES-1].ctl_q.carry;
   assign bus.out_sum   = g_st[STAGES-1].sum_q;

`ifdef ADDER_PIPE_OVF_EN
   localparam int unsigned LSW = seg_w(STAGES - 1, WIDTH, SEG);

   logic a_msb, b_msb, s_msb, ovf_q;

   // Operand MSBs are the top bits of the final segment, so no extra skew is needed.
   assign a_msb = g_st[STAGES-1].a_rem[LSW-1];
   assign b_msb = g_st[STAGES-1].b_rem[LSW-1];
   assign s_msb = g_st[STAGES-1].s_seg[LSW-1];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else if (adv) begin
         ovf_q <= (a_msb == b_msb) && (s_msb != a_msb);
      end
   end

   assign bus.out_ovf = ovf_q;
`else
   assign bus.out_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_adder_pipe_nbit.sv
// Bench for adder_pipe_nbit: 32/8 instance with a result scoreboard, plus a 3/1 instance.
module tb_adder_pipe_nbit;

`ifdef ADDER_PIPE_OVF_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   typedef struct {
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   passes = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   adder_pipe_nbit_if #(.WIDTH(32)) bus ();
   adder_pipe_nbit_if #(.WIDTH(3))  bus3 ();

   adder_pipe_nbit #(.WIDTH(32), .SEG(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   adder_pipe_nbit #(.WIDTH(3), .SEG(1)) dut3 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus3)
   );

   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic cin);
      logic [32:0] t;
      exp_t        r;
      t      = {1'b0, a} + {1'b0, b} + {32'd0, cin};
      r.sum  = t[31:0];
      r.cout = t[32];
      r.ovf  = OVF_EN && (a[31] == b[31]) && (t[31] != a[31]);
      return r;
   endfunction

   // Scoreboard: push on accepted operands, pop and compare on delivered results.
   always @(negedge clk) begin
      if (!rst_n) begin
         sb.delete();
      end else begin
         if (bus.out_valid && bus.out_ready) begin
            checks++;
            if (sb.size() == 0) begin
               $display("FAIL sb_unexpected: got sum=%h cout=%b, required no result", bus.out_sum,
                        bus.out_cout);
            end else begin
               exp_t e;
               e = sb.pop_front();
               if (bus.out_sum !== e.sum || bus.out_cout !== e.cout || bus.out_ovf !== e.ovf)
                  $display("FAIL sb_result: got sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
                           bus.out_sum, bus.out_cout, bus.out_ovf, e.sum, e.cout, e.ovf);
               else
                  passes++;
            end
         end
         if (bus.in_valid && bus.in_ready)
            sb.push_back(model(bus.in_a, bus.in_b, bus.in_cin));
      end
   end

   task automatic drive_rand();
      bus.in_valid = 1'b1;
      bus.in_a     = $urandom;
      bus.in_b     = $urandom;
      bus.in_cin   = 1'($urandom_range(0, 1));
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive_rand();
      bus.out_ready  = 1'b1;
      bus3.in_valid  = 1'b1;
      bus3.in_a      = 3'd5;
      bus3.in_b      = 3'd6;
      bus3.in_cin    = 1'b1;
      bus3.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.out_sum !== 32'd0 || bus.out_cout !== 1'b0 ||
          bus.in_ready !== 1'b1 || bus.out_ovf !== 1'b0)
         $display("FAIL reset_state: got v=%b sum=%h cout=%b rdy=%b ovf=%b, required 0/0/0/1/0",
                  bus.out_valid, bus.out_sum, bus.out_cout, bus.in_ready, bus.out_ovf);
      else
         passes++;
      checks++;
      if (bus3.out_valid !== 1'b0 || bus3.in_ready !== 1'b1)
         $display("FAIL reset_small: got v=%b rdy=%b, required 0/1", bus3.out_valid, bus3.in_ready);
      else
         passes++;
      @(posedge clk);
      #1;
      rst_n         = 1'b1;
      bus.in_valid  = 1'b0;
      bus3.in_valid = 1'b0;
   endtask

   task automatic test_carry();
      bus.in_valid  = 1'b1;
      bus.in_a      = 32'hFFFF_FFFF;
      bus.in_b      = 32'h0000_0001;
      bus.in_cin    = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1 bus.in_valid = 1'b0;
         @(negedge clk);
         checks++;
         if (i < 3) begin
            if (bus.out_valid !== 1'b0)
               $display("FAIL carry_latency: edge E+%0d got out_valid=%b, required 0", i, bus.out_valid);
            else
               passes++;
         end else begin
            if (bus.out_valid !== 1'b1 || bus.out_sum !== 32'd0 || bus.out_cout !== 1'b1)
               $display("FAIL carry_ripple: got v=%b sum=%h cout=%b, required 1/00000000/1",
                        bus.out_valid, bus.out_sum, bus.out_cout);
            else
               passes++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_stream();
      bus.out_ready = 1'b1;
      drive_rand();
      for (int cyc = 0; cyc < 12; cyc++) begin
         logic exp_v;
         @(posedge clk);
         #1;
         if (cyc + 1 < 8) drive_rand();
         else bus.in_valid = 1'b0;
         @(negedge clk);
         exp_v = (cyc >= 3 && cyc <= 10);
         checks++;
         if (bus.out_valid !== exp_v)
            $display("FAIL stream_valid: edge E+%0d got out_valid=%b, required %b", cyc,
                     bus.out_valid, exp_v);
         else
            passes++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_backpressure();
      int          fill;
      logic [31:0] snap_s;
      logic        snap_c, snap_o;
      fill          = 0;
      bus.out_ready = 1'b0;
      drive_rand();
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1 drive_rand();
         @(negedge clk);
         if (!bus.in_ready) begin
            fill = i + 1;
            break;
         end
      end
      checks++;
      if (fill !== 4)
         $display("FAIL bp_fill: in_ready dropped after %0d accepts, required 4", fill);
      else
         passes++;
      snap_s = bus.out_sum;
      snap_c = bus.out_cout;
      snap_o = bus.out_ovf;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1 drive_rand();
         @(negedge clk);
         checks++;
         if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_sum !== snap_s ||
             bus.out_cout !== snap_c || bus.out_ovf !== snap_o)
            $display("FAIL bp_frozen: cycle %0d got rdy=%b v=%b sum=%h cout=%b, required 0/1/%h/%b",
                     i, bus.in_ready, bus.out_valid, bus.out_sum, bus.out_cout, snap_s, snap_c);
         else
            passes++;
      end
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      checks++;
      if (sb.size() !== 0 || bus.out_valid !== 1'b0)
         $display("FAIL bp_drain: got %0d outstanding, out_valid=%b, required 0/0", sb.size(),
                  bus.out_valid);
      else
         passes++;
   endtask

   task automatic test_reset_midflight();
      bus.out_ready = 1'b1;
      drive_rand();
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         if (i < 2) begin
            drive_rand();
         end else begin
            bus.in_valid = 1'b0;
            rst_n        = 1'b0;
         end
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         checks++;
         if (bus.out_valid !== 1'b0)
            $display("FAIL midreset_stale: cycle %0d got out_valid=%b sum=%h, required 0", j,
                     bus.out_valid, bus.out_sum);
         else
            passes++;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_small();
      logic [2:0] ta[3] = '{3'd7, 3'd3, 3'd4};
      logic [2:0] tb[3] = '{3'd1, 3'd2, 3'd5};
      logic       tc[3] = '{1'b1, 1'b0, 1'b1};
      logic [2:0] es[3] = '{3'd1, 3'd5, 3'd2};
      logic       ec[3] = '{1'b1, 1'b0, 1'b1};
      for (int t = 0; t < 3; t++) begin
         bus3.in_valid = 1'b1;
         bus3.in_a     = ta[t];
         bus3.in_b     = tb[t];
         bus3.in_cin   = tc[t];
         for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 bus3.in_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (i < 2) begin
               if (bus3.out_valid !== 1'b0)
                  $display("FAIL small_latency: op %0d edge E+%0d got out_valid=%b, required 0", t, i,
                           bus3.out_valid);
               else
                  passes++;
            end else begin
               if (bus3.out_valid !== 1'b1 || bus3.out_sum !== es[t] || bus3.out_cout !== ec[t])
                  $display("FAIL small_sum: op %0d got v=%b sum=%0d cout=%b, required 1/%0d/%b", t,
                           bus3.out_valid, bus3.out_sum, bus3.out_cout, es[t], ec[t]);
               else
                  passes++;
            end
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_ovf();
      logic [31:0] ta[3] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0001};
      logic [31:0] tb[3] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0002};
      logic [31:0] es[3] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0003};
      logic        ec[3] = '{1'b0, 1'b1, 1'b0};
      logic        eo[3] = '{OVF_EN, OVF_EN, 1'b0};
      bus.out_ready = 1'b1;
      for (int t = 0; t < 3; t++) begin
         bus.in_valid = 1'b1;
         bus.in_a     = ta[t];
         bus.in_b     = tb[t];
         bus.in_cin   = 1'b0;
         for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1 bus.in_valid = 1'b0;
         end
         @(negedge clk);
         checks++;
         if (bus.out_valid !== 1'b1 || bus.out_sum !== es[t] || bus.out_cout !== ec[t] ||
             bus.out_ovf !== eo[t])
            $display("FAIL ovf_case: op %0d got v=%b sum=%h cout=%b ovf=%b, required 1/%h/%b/%b", t,
                     bus.out_valid, bus.out_sum, bus.out_cout, bus.out_ovf, es[t], ec[t], eo[t]);
         else
            passes++;
         @(posedge clk);
         #1;
      end
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (sb.size() !== 0)
         $display("FAIL final_drain: got %0d results outstanding, required 0", sb.size());
      else
         passes++;
   endtask

   initial begin
      rst_n          = 1'b0;
      bus.in_valid   = 1'b0;
      bus.in_a       = '0;
      bus.in_b       = '0;
      bus.in_cin     = 1'b0;
      bus.out_ready  = 1'b1;
      bus3.in_valid  = 1'b0;
      bus3.in_a      = '0;
      bus3.in_b      = '0;
      bus3.in_cin    = 1'b0;
      bus3.out_ready = 1'b1;
      test_reset();
      test_carry();
      test_stream();
      test_backpressure();
      test_reset_midflight();
      test_small();
      test_ovf();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
